rr_arb_lock: RTL and testbench

RR_ARB_LOCK -- requirements
Module: rr_arb_lock

---
 rtl/rr_arb_lock.sv | 161 ++++++++++++++++
 tb/tb_rr_arb_lock.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with grant locking: a winner keeps its grant until done,
// then the next requester after it (modulo NUM_REQ) is granted with no idle bubble.
module rr_arb_lock #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Wrap at NUM_REQ rather than 2^IDX_W so unused indices are never visited.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        if (i == LAST_IDX) begin
            r = '0;
        end else begin
            r = i + IDX_W'(1);
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
    logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0]   gnt_idx_r, gnt_idx_nxt_s;
    logic               gnt_vld_r, gnt_vld_nxt_s;
    logic [IDX_W-1:0]   base_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               found_s;

    // Search base: the holder that is finishing while BUSY, else the last winner.
    always_comb begin
        if (state_r == BUSY) begin
            base_s = gnt_idx_r;
        end else begin
            base_s = ptr_r;
        end
    end

    // First set request bit in the order base+1, base+2, ..., base.
    always_comb begin : search
        logic [IDX_W-1:0] cand_s;
        found_s   = 1'b0;
        win_idx_s = '0;
        cand_s    = wrap_inc(base_s);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && req[cand_s]) begin
                found_s   = 1'b1;
                win_idx_s = cand_s;
            end else begin
                found_s   = found_s;
            end
            cand_s = wrap_inc(cand_s);
        end
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= LAST_IDX;
            gnt_r     <= '0;
            gnt_idx_r <= '0;
            gnt_vld_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            gnt_r     <= gnt_nxt_s;
            gnt_idx_r <= gnt_idx_nxt_s;
            gnt_vld_r <= gnt_vld_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (done && !found_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next grant and pointer values; the pointer moves only when a transfer ends.
    always_comb begin
        ptr_nxt_s     = ptr_r;
        gnt_nxt_s     = gnt_r;
        gnt_idx_nxt_s = gnt_idx_r;
        gnt_vld_nxt_s = gnt_vld_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_nxt_s     = to_onehot(win_idx_s);
                    gnt_idx_nxt_s = win_idx_s;
                    gnt_vld_nxt_s = 1'b1;
                end else begin
                    gnt_nxt_s     = '0;
                    gnt_idx_nxt_s = '0;
                    gnt_vld_nxt_s = 1'b0;
                end
            end
            BUSY: begin
                if (done) begin
                    ptr_nxt_s = gnt_idx_r;
                    if (found_s) begin
                        gnt_nxt_s     = to_onehot(win_idx_s);
                        gnt_idx_nxt_s = win_idx_s;
                        gnt_vld_nxt_s = 1'b1;
                    end else begin
                        gnt_nxt_s     = '0;
                        gnt_idx_nxt_s = '0;
                        gnt_vld_nxt_s = 1'b0;
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            default: begin
                gnt_nxt_s     = '0;
                gnt_idx_nxt_s = '0;
                gnt_vld_nxt_s = 1'b0;
            end
        endcase
    end

    assign gnt     = gnt_r;
    assign gnt_idx = gnt_idx_r;
    assign gnt_vld = gnt_vld_r;

endmodule

// File: tb/tb_rr_arb_lock.sv
// Bench for rr_arb_lock: a 3-requester and a 5-requester instance driven from
// per-scenario tables, with expected grants queued at drive time and checked after each edge.
module tb_rr_arb_lock;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;

    logic       rst5;
    logic [4:0] req5;
    logic       done5;
    logic [4:0] gnt5;
    logic [2:0] gnt_idx5;
    logic       gnt_vld5;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } exp3_t;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } exp5_t;

    exp3_t exp_q[$];
    exp5_t exp5_q[$];
    int    checks = 0;
    int    errors = 0;

    rr_arb_lock #(.NUM_REQ(3)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
    );

    rr_arb_lock #(.NUM_REQ(5)) dut5 (
        .clk(clk), .rst(rst5), .req(req5), .done(done5),
        .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_vld(gnt_vld5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row layout: {rst, done, req[2:0], exp_gnt[2:0], exp_idx[1:0], exp_vld}
    task automatic test_reset();
        logic [10:0] tbl [2] = '{
            {1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0},
            {1'b1, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0}
        };
        exp3_t e;
        for (int i = 0; i < 2; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL reset[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL reset[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL reset[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    task automatic test_first_grant();
        exp3_t e;
        rst = 1'b0; done = 1'b0; req = 3'b111;
        exp_q.push_back(exp3_t'{gnt: 3'b001, idx: 2'd0, vld: 1'b1});
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks += 3;
        if (gnt !== e.gnt) begin errors++; $display("FAIL first_grant gnt got %b want %b", gnt, e.gnt); end
        if (gnt_idx !== e.idx) begin errors++; $display("FAIL first_grant gnt_idx got %0d want %0d", gnt_idx, e.idx); end
        if (gnt_vld !== e.vld) begin errors++; $display("FAIL first_grant gnt_vld got %b want %b", gnt_vld, e.vld); end
    endtask

    task automatic test_lock();
        exp3_t e;
        for (int i = 0; i < 5; i++) begin
            rst = 1'b0; done = 1'b0; req = 3'b110;
            exp_q.push_back(exp3_t'{gnt: 3'b001, idx: 2'd0, vld: 1'b1});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL lock[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL lock[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL lock[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    task automatic test_rotation();
        logic [10:0] tbl [4] = '{
            {1'b0, 1'b1, 3'b111, 3'b010, 2'd1, 1'b1},
            {1'b0, 1'b1, 3'b111, 3'b100, 2'd2, 1'b1},
            {1'b0, 1'b1, 3'b111, 3'b001, 2'd0, 1'b1},
            {1'b0, 1'b0, 3'b111, 3'b001, 2'd0, 1'b1}
        };
        exp3_t e;
        for (int i = 0; i < 4; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL rotation[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL rotation[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL rotation[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    // done in IDLE must not disturb the pointer left at 0 by the last transfer.
    task automatic test_idle_done();
        logic [10:0] tbl [4] = '{
            {1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0},
            {1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0},
            {1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0},
            {1'b0, 1'b0, 3'b111, 3'b010, 2'd1, 1'b1}
        };
        exp3_t e;
        for (int i = 0; i < 4; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL idle_done[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL idle_done[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL idle_done[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    task automatic test_solo();
        logic [10:0] tbl [3] = '{
            {1'b0, 1'b1, 3'b010, 3'b010, 2'd1, 1'b1},
            {1'b0, 1'b1, 3'b010, 3'b010, 2'd1, 1'b1},
            {1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0}
        };
        exp3_t e;
        for (int i = 0; i < 3; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL solo[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL solo[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL solo[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    // Pointer is 1 here: requesters 0 and 1 must alternate, finisher lowest.
    task automatic test_low_prio();
        logic [10:0] tbl [4] = '{
            {1'b0, 1'b0, 3'b011, 3'b001, 2'd0, 1'b1},
            {1'b0, 1'b1, 3'b011, 3'b010, 2'd1, 1'b1},
            {1'b0, 1'b1, 3'b011, 3'b001, 2'd0, 1'b1},
            {1'b0, 1'b1, 3'b011, 3'b010, 2'd1, 1'b1}
        };
        exp3_t e;
        for (int i = 0; i < 4; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL low_prio[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL low_prio[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL low_prio[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    task automatic test_mid_reset();
        logic [10:0] tbl [5] = '{
            {1'b0, 1'b1, 3'b100, 3'b100, 2'd2, 1'b1},
            {1'b1, 1'b0, 3'b100, 3'b000, 2'd0, 1'b0},
            {1'b0, 1'b0, 3'b101, 3'b001, 2'd0, 1'b1},
            {1'b0, 1'b0, 3'b000, 3'b001, 2'd0, 1'b1},
            {1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0}
        };
        exp3_t e;
        for (int i = 0; i < 5; i++) begin
            {rst, done, req} = tbl[i][10:6];
            exp_q.push_back(exp3_t'{gnt: tbl[i][5:3], idx: tbl[i][2:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (gnt !== e.gnt) begin errors++; $display("FAIL mid_reset[%0d] gnt got %b want %b", i, gnt, e.gnt); end
            if (gnt_idx !== e.idx) begin errors++; $display("FAIL mid_reset[%0d] gnt_idx got %0d want %0d", i, gnt_idx, e.idx); end
            if (gnt_vld !== e.vld) begin errors++; $display("FAIL mid_reset[%0d] gnt_vld got %b want %b", i, gnt_vld, e.vld); end
        end
    endtask

    // Row layout: {rst, done, req[4:0], exp_gnt[4:0], exp_idx[2:0], exp_vld}
    task automatic test_wrap5();
        logic [15:0] tbl [9] = '{
            {1'b1, 1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0},
            {1'b0, 1'b0, 5'b10000, 5'b10000, 3'd4, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b00001, 3'd0, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b00010, 3'd1, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b00100, 3'd2, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b01000, 3'd3, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b10000, 3'd4, 1'b1},
            {1'b0, 1'b1, 5'b11111, 5'b00001, 3'd0, 1'b1},
            {1'b0, 1'b1, 5'b00000, 5'b00000, 3'd0, 1'b0}
        };
        exp5_t e;
        for (int i = 0; i < 9; i++) begin
            {rst5, done5, req5} = tbl[i][15:9];
            exp5_q.push_back(exp5_t'{gnt: tbl[i][8:4], idx: tbl[i][3:1], vld: tbl[i][0]});
            @(posedge clk); #1;
            e = exp5_q.pop_front();
            checks += 3;
            if (gnt5 !== e.gnt) begin errors++; $display("FAIL wrap5[%0d] gnt got %b want %b", i, gnt5, e.gnt); end
            if (gnt_idx5 !== e.idx) begin errors++; $display("FAIL wrap5[%0d] gnt_idx got %0d want %0d", i, gnt_idx5, e.idx); end
            if (gnt_vld5 !== e.vld) begin errors++; $display("FAIL wrap5[%0d] gnt_vld got %b want %b", i, gnt_vld5, e.vld); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b000;
        done  = 1'b0;
        rst5  = 1'b1;
        req5  = 5'b00000;
        done5 = 1'b0;
        test_reset();
        test_first_grant();
        test_lock();
        test_rotation();
        test_idle_done();
        test_solo();
        test_low_prio();
        test_mid_reset();
        test_wrap5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
